// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
//   Shared definitions for the GeMM CIM job sequencer: the sequencer state
//   type, the idle levels of the CIM macro controls and the default geometry
//   of the weight array as seen on the CIM address bus.
// -----------------------------------------------------------------------------
package cim_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CLR      = 3'd2,
    S_COMP     = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_RD_HOLD  = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // CIM control levels whenever the macro is not being exercised.
  // cim_cimeb is active-low, so its idle level is 1.
  localparam logic CIM_CIMEB_IDLE = 1'b1;
  localparam logic CIM_WEB_IDLE   = 1'b0;
  localparam logic CIM_PSUM_IDLE  = 1'b0;
  localparam logic CIM_CLR_IDLE   = 1'b0;

  // Weight array geometry on the CIM address bus.
  localparam int unsigned ROW_STRIDE_DEF = 128;
  localparam int unsigned WORD_BYTES     = 4;

endpackage

// File: rtl/cim_waddr_gen.sv
// -----------------------------------------------------------------------------
// cim_waddr_gen
//   Maps a weight word counter k onto a CIM byte address:
//     addr = (k / WORDS_PER_ROW) * ROW_STRIDE + (k % WORDS_PER_ROW) * 4
//   Ports:
//     word_idx  in  CNT_W  running weight word index (0-based)
//     byte_addr out 32     CIM byte address for that word
// -----------------------------------------------------------------------------
module cim_waddr_gen
  import cim_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned WORDS_PER_ROW = 2,
  parameter int unsigned ROW_STRIDE    = ROW_STRIDE_DEF
) (
  input  logic [CNT_W-1:0] word_idx,
  output logic [31:0]      byte_addr
);

  logic [31:0] k;
  logic [31:0] row;
  logic [31:0] col;

  always_comb begin
    k         = 32'(word_idx);
    row       = k / 32'(WORDS_PER_ROW);
    col       = k % 32'(WORDS_PER_ROW);
    byte_addr = row * 32'(ROW_STRIDE) + col * 32'(WORD_BYTES);
  end

endmodule

// File: rtl/cim_job_sequencer.sv
// -----------------------------------------------------------------------------
// cim_job_sequencer
//   Runs one GeMM job on the CIM macro: optional weight load, output-register
//   clear, cfg_n_inputs accumulate cycles, then N_OUT result reads. Sole
//   driver of the CIM control pins.
//   Ports:
//     clk, rst_n                    clock / async active-low reset
//     start, cfg_w_words,
//     cfg_n_inputs                  job request and its counts (latched on start)
//     w_valid/w_ready/w_data        weight word stream (sink)
//     in_valid/in_ready/in_data     input vector stream (sink)
//     out_valid/out_ready/out_data,
//     out_idx                       result stream (source) with register index
//     busy, done                    job in progress / one-cycle end pulse
//     cim_*                         CIM macro controls, address, data, result
// -----------------------------------------------------------------------------
module cim_job_sequencer
  import cim_pkg::*;
#(
  parameter int unsigned N_OUT         = 8,
  parameter int unsigned WORDS_PER_ROW = 2,
  parameter int unsigned ROW_STRIDE    = ROW_STRIDE_DEF,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_w_words,
  input  logic [CNT_W-1:0] cfg_n_inputs,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [31:0]      w_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_idx,
  output logic             busy,
  output logic             done,
  output logic             cim_cs,
  output logic             cim_web,
  output logic             cim_cimeb,
  output logic             cim_partial_sum_eb,
  output logic             cim_reset_output_reg,
  output logic [3:0]       cim_output_reg,
  output logic [31:0]      cim_address,
  output logic [31:0]      cim_input_data,
  input  logic [31:0]      cim_output
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cfg_w_q, cfg_w_d;
  logic [CNT_W-1:0]  cfg_n_q, cfg_n_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       res_q, res_d;
  logic [31:0]       waddr;

  cim_waddr_gen #(
    .CNT_W         (CNT_W),
    .WORDS_PER_ROW (WORDS_PER_ROW),
    .ROW_STRIDE    (ROW_STRIDE)
  ) u_waddr_gen (
    .word_idx  (w_cnt_q),
    .byte_addr (waddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_w_q    <= '0;
      cfg_n_q    <= '0;
      w_cnt_q    <= '0;
      in_cnt_q   <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cfg_w_q    <= cfg_w_d;
      cfg_n_q    <= cfg_n_d;
      w_cnt_q    <= w_cnt_d;
      in_cnt_q   <= in_cnt_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_w_d    = cfg_w_q;
    cfg_n_d    = cfg_n_q;
    w_cnt_d    = w_cnt_q;
    in_cnt_d   = in_cnt_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    res_d      = res_q;

    w_ready              = 1'b0;
    in_ready             = 1'b0;
    out_valid            = 1'b0;
    out_data             = '0;
    out_idx              = '0;
    done                 = 1'b0;
    cim_web              = CIM_WEB_IDLE;
    cim_cimeb            = CIM_CIMEB_IDLE;
    cim_partial_sum_eb   = CIM_PSUM_IDLE;
    cim_reset_output_reg = CIM_CLR_IDLE;
    cim_output_reg       = '0;
    cim_address          = '0;
    cim_input_data       = '0;

    busy   = (state_q != S_IDLE);
    cim_cs = busy;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_w_d  = cfg_w_words;
          cfg_n_d  = cfg_n_inputs;
          w_cnt_d  = '0;
          in_cnt_d = '0;
          idx_d    = '0;
          state_d  = (cfg_w_words != '0) ? S_LOAD : S_CLR;
        end
      end

      // Write strobe, data and address only exist in the handshake cycle.
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          cim_web        = 1'b1;
          cim_input_data = w_data;
          cim_address    = waddr;
          w_cnt_d        = w_cnt_q + CNT_W'(1);
          if (w_cnt_q == cfg_w_q - CNT_W'(1)) begin
            state_d = S_CLR;
          end
        end
      end

      S_CLR: begin
        cim_reset_output_reg = 1'b1;
        idx_d   = '0;
        state_d = (cfg_n_q != '0) ? S_COMP : S_RD_ISSUE;
      end

      // Bubbles leave the macro idle; only accepted vectors accumulate.
      S_COMP: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cim_cimeb          = 1'b0;
          cim_partial_sum_eb = 1'b1;
          cim_input_data     = in_data;
          in_cnt_d           = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == cfg_n_q - CNT_W'(1)) begin
            idx_d   = '0;
            state_d = S_RD_ISSUE;
          end
        end
      end

      S_RD_ISSUE: begin
        cim_output_reg = idx_q;
        wait_cnt_d     = '0;
        state_d        = S_RD_WAIT;
      end

      // cim_output is valid in the RD_LAT-th cycle after the select change;
      // it is captured at the end of that cycle.
      S_RD_WAIT: begin
        cim_output_reg = idx_q;
        if (wait_cnt_q == WAIT_W'(RD_LAT - 1)) begin
          res_d   = cim_output;
          state_d = S_RD_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      S_RD_HOLD: begin
        cim_output_reg = idx_q;
        out_valid      = 1'b1;
        out_data       = res_q;
        out_idx        = idx_q;
        if (out_ready) begin
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
